icache_mem_arbiter: RTL and testbench

- Shares the single instruction-side memory port between icache demand misses and the next-line prefetcher.
- Buffers prefetch addresses in a small FIFO and issues one LOAD per cycle when the data cache does not own the bus.
- Tracks in-flight transactions by memory transaction tag and returns each fill to the icache, marked demand or prefetch.
- Sits between the icache/prefetcher and the shared memory mux.

---
 rtl/icache_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_icache_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_arbiter.sv
// Instruction-side memory port arbiter: icache demand misses take priority over a small
// prefetch FIFO, and a tag table routes each returning line back to the icache as a fill.
module icache_mem_arbiter #(
  parameter int PF_DEPTH = 4,
  parameter int NUM_TAGS = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        demand_valid,
  input  logic [31:0] demand_addr,
  output logic        demand_ready,
  input  logic        pref_valid,
  input  logic [31:0] pref_addr,
  output logic        pref_ready,
  input  logic        dmem_claim,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  input  logic [3:0]  mem2proc_transaction_tag,
  input  logic [3:0]  mem2proc_data_tag,
  input  logic [63:0] mem2proc_data,
  output logic        fill_valid,
  output logic [31:0] fill_addr,
  output logic [63:0] fill_data,
  output logic        fill_is_prefetch,
  output logic [3:0]  outstanding_cnt,
  output logic        tag_err
);
  localparam int PTR_W = $clog2(PF_DEPTH);
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [31:0]       fifo_q [PF_DEPTH];
  logic [31:0]       fifo_d [PF_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_TAGS:0] valid_q, valid_d, is_pf_q, is_pf_d;
  logic [31:0]       addr_q [NUM_TAGS+1];
  logic [31:0]       addr_d [NUM_TAGS+1];
  logic              fill_valid_q, fill_valid_d, fill_is_pf_q, fill_is_pf_d;
  logic [31:0]       fill_addr_q, fill_addr_d;
  logic [63:0]       fill_data_q, fill_data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              tag_err_q, tag_err_d;

  logic [31:0]       demand_line, pref_line, head_line, req_addr;
  logic [PTR_W:0]    occupancy;
  logic              fifo_empty, fifo_full;
  logic [NUM_TAGS:0] demand_match, head_match;
  logic [1:0]        cmd;
  logic              req_is_pf, demand_ok, promote, pop, push, accept;
  logic              unused_offset_bits;

  assign demand_line = {demand_addr[31:3], 3'b000};
  assign pref_line   = {pref_addr[31:3], 3'b000};
  assign head_line   = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign fifo_full   = occupancy[PTR_W];
  assign fifo_empty  = (occupancy == '0);
  assign unused_offset_bits = ^{demand_addr[2:0], pref_addr[2:0]};

  always_comb begin
    demand_match = '0;
    head_match   = '0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      demand_match[i] = valid_q[i] && (addr_q[i] == demand_line);
      head_match[i]   = valid_q[i] && (addr_q[i] == head_line);
    end
  end

  // Demand beats prefetch; a line already in flight never gets a second LOAD.
  always_comb begin
    cmd       = CMD_NONE;
    req_addr  = '0;
    req_is_pf = 1'b0;
    demand_ok = 1'b0;
    promote   = 1'b0;
    pop       = 1'b0;
    if (!dmem_claim) begin
      if (demand_valid) begin
        if (|demand_match) begin
          demand_ok = 1'b1;
          promote   = 1'b1;
        end else begin
          cmd       = CMD_LOAD;
          req_addr  = demand_line;
          demand_ok = (mem2proc_transaction_tag != 4'd0);
        end
      end else if (!fifo_empty) begin
        if (|head_match) begin
          pop = 1'b1;
        end else begin
          cmd       = CMD_LOAD;
          req_addr  = head_line;
          req_is_pf = 1'b1;
          pop       = (mem2proc_transaction_tag != 4'd0);
        end
      end
    end
  end

  assign accept = (cmd == CMD_LOAD) && (mem2proc_transaction_tag != 4'd0);
  assign push   = pref_valid && (!fifo_full || pop);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[PTR_W-1:0]] = pref_line;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Promote, then free the returning tag, then allocate: a tag may be reused in the cycle it returns.
  always_comb begin
    valid_d      = valid_q;
    is_pf_d      = is_pf_q;
    addr_d       = addr_q;
    tag_err_d    = tag_err_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    fill_is_pf_d = fill_is_pf_q;
    if (promote) begin
      is_pf_d = is_pf_q & ~demand_match;
    end
    if (mem2proc_data_tag != 4'd0) begin
      if (valid_q[mem2proc_data_tag]) begin
        fill_valid_d = 1'b1;
        fill_addr_d  = addr_q[mem2proc_data_tag];
        fill_data_d  = mem2proc_data;
        fill_is_pf_d = is_pf_d[mem2proc_data_tag];
        valid_d[mem2proc_data_tag] = 1'b0;
      end else begin
        tag_err_d = 1'b1;
      end
    end
    if (accept) begin
      if (valid_d[mem2proc_transaction_tag]) begin
        tag_err_d = 1'b1;
      end
      valid_d[mem2proc_transaction_tag] = 1'b1;
      addr_d[mem2proc_transaction_tag]  = req_addr;
      is_pf_d[mem2proc_transaction_tag] = req_is_pf;
    end
    cnt_d = 4'($countones(valid_d));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PF_DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i <= NUM_TAGS; i++) addr_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      valid_q      <= '0;
      is_pf_q      <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      fill_is_pf_q <= 1'b0;
      cnt_q        <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      addr_q       <= addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      valid_q      <= valid_d;
      is_pf_q      <= is_pf_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      fill_is_pf_q <= fill_is_pf_d;
      cnt_q        <= cnt_d;
      tag_err_q    <= tag_err_d;
    end
  end

  // Combinational outputs are forced idle while reset is held so nothing issues mid-reset.
  assign proc2mem_command = reset ? CMD_NONE : cmd;
  assign proc2mem_addr    = reset ? 32'd0 : req_addr;
  assign demand_ready     = !reset && demand_ok;
  assign pref_ready       = reset || !fifo_full;
  assign fill_valid       = fill_valid_q;
  assign fill_addr        = fill_addr_q;
  assign fill_data        = fill_data_q;
  assign fill_is_prefetch = fill_is_pf_q;
  assign outstanding_cnt  = cnt_q;
  assign tag_err          = tag_err_q;
endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Self-checking bench for icache_mem_arbiter: directed scenarios, then random traffic
// checked against a queue/array reference model of the arbitration and tag rules.
module tb_icache_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        demand_valid, pref_valid, dmem_claim;
  logic [31:0] demand_addr, pref_addr;
  logic        demand_ready, pref_ready;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_transaction_tag, mem2proc_data_tag;
  logic [63:0] mem2proc_data;
  logic        fill_valid, fill_is_prefetch, tag_err;
  logic [31:0] fill_addr;
  logic [63:0] fill_data;
  logic [3:0]  outstanding_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit          m_valid [16];
  logic [31:0] m_addr  [16];
  bit          m_pf    [16];
  logic [31:0] m_fifo  [$];
  logic        m_fv, m_fp, m_err;
  logic [31:0] m_fa;
  logic [63:0] m_fd;

  always #5 clock = ~clock;

  icache_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .demand_valid(demand_valid), .demand_addr(demand_addr), .demand_ready(demand_ready),
    .pref_valid(pref_valid), .pref_addr(pref_addr), .pref_ready(pref_ready),
    .dmem_claim(dmem_claim),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .mem2proc_transaction_tag(mem2proc_transaction_tag),
    .mem2proc_data_tag(mem2proc_data_tag), .mem2proc_data(mem2proc_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_is_prefetch(fill_is_prefetch),
    .outstanding_cnt(outstanding_cnt), .tag_err(tag_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_idle();
    demand_valid = 1'b0; demand_addr = '0;
    pref_valid = 1'b0; pref_addr = '0;
    dmem_claim = 1'b0;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction

  function automatic bit in_flight(input logic [31:0] ln);
    for (int t = 1; t < 16; t++) if (m_valid[t] && m_addr[t] == ln) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] pick_tag(input bit want_valid);
    int s = $urandom_range(1, 15);
    for (int k = 0; k < 15; k++) begin
      int t = ((s - 1 + k) % 15) + 1;
      if (m_valid[t] == want_valid) return 4'(t);
    end
    return 4'd0;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int t = 1; t < 16; t++) c += int'(m_valid[t]);
    return c;
  endfunction

  task automatic test_reset();
    set_idle();
    demand_valid = 1'b1; demand_addr = 32'h1234; pref_valid = 1'b1;
    mem2proc_transaction_tag = 4'd3;
    #1 reset = 1'b1;
    #2;
    n_chk++; if ({proc2mem_command, proc2mem_addr} !== 34'd0) $display("[TB] FAIL reset_cmd got=%0d/%h exp=0/0", proc2mem_command, proc2mem_addr); else n_pass++;
    n_chk++; if ({demand_ready, pref_ready} !== 2'b01) $display("[TB] FAIL reset_ready got=%b exp=01", {demand_ready, pref_ready}); else n_pass++;
    n_chk++; if ({fill_valid, fill_addr, fill_data, fill_is_prefetch} !== 98'd0) $display("[TB] FAIL reset_fill got=%b/%h/%h/%b exp=0", fill_valid, fill_addr, fill_data, fill_is_prefetch); else n_pass++;
    n_chk++; if ({outstanding_cnt, tag_err} !== 5'd0) $display("[TB] FAIL reset_status got=%0d/%b exp=0/0", outstanding_cnt, tag_err); else n_pass++;
    tick();
    set_idle();
    reset = 1'b0;
  endtask

  task automatic test_demand_fill();
    do_reset();
    demand_valid = 1'b1; demand_addr = 32'h1004; mem2proc_transaction_tag = 4'd3;
    settle();
    n_chk++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h1000) $display("[TB] FAIL demand_load got=%0d/%h exp=1/00001000", proc2mem_command, proc2mem_addr); else n_pass++;
    n_chk++; if (demand_ready !== 1'b1) $display("[TB] FAIL demand_ready got=%b exp=1", demand_ready); else n_pass++;
    tick();
    set_idle();
    tick();
    mem2proc_data_tag = 4'd3; mem2proc_data = 64'hDEAD;
    settle();
    n_chk++; if (outstanding_cnt !== 4'd1) $display("[TB] FAIL demand_cnt got=%0d exp=1", outstanding_cnt); else n_pass++;
    tick();
    set_idle();
    settle();
    n_chk++; if ({fill_valid, fill_addr, fill_data, fill_is_prefetch} !== {1'b1, 32'h1000, 64'hDEAD, 1'b0}) $display("[TB] FAIL demand_fill got=%b/%h/%h/%b exp=1/00001000/dead/0", fill_valid, fill_addr, fill_data, fill_is_prefetch); else n_pass++;
    n_chk++; if (outstanding_cnt !== 4'd0) $display("[TB] FAIL demand_cnt_after got=%0d exp=0", outstanding_cnt); else n_pass++;
    tick();
    n_chk++; if (fill_valid !== 1'b0 || fill_addr !== 32'h1000) $display("[TB] FAIL fill_pulse_hold got=%b/%h exp=0/00001000", fill_valid, fill_addr); else n_pass++;
  endtask

  task automatic test_claim_prefetch();
    do_reset();
    dmem_claim = 1'b1; pref_valid = 1'b1; pref_addr = 32'h2000;
    tick();
    pref_addr = 32'h2008;
    tick();
    pref_valid = 1'b0;
    settle();
    n_chk++; if (proc2mem_command !== 2'd0) $display("[TB] FAIL claim_none got=%0d exp=0", proc2mem_command); else n_pass++;
    tick();
    dmem_claim = 1'b0; mem2proc_transaction_tag = 4'd1;
    settle();
    n_chk++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h2000) $display("[TB] FAIL pf_load0 got=%0d/%h exp=1/00002000", proc2mem_command, proc2mem_addr); else n_pass++;
    tick();
    mem2proc_transaction_tag = 4'd2;
    settle();
    n_chk++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h2008) $display("[TB] FAIL pf_load1 got=%0d/%h exp=1/00002008", proc2mem_command, proc2mem_addr); else n_pass++;
    tick();
    mem2proc_transaction_tag = 4'd0;
    settle();
    n_chk++; if (proc2mem_command !== 2'd0 || outstanding_cnt !== 4'd2) $display("[TB] FAIL pf_drained got=%0d/%0d exp=0/2", proc2mem_command, outstanding_cnt); else n_pass++;
  endtask

  task automatic test_promotion();
    do_reset();
    pref_valid = 1'b1; pref_addr = 32'h3000;
    tick();
    pref_valid = 1'b0; mem2proc_transaction_tag = 4'd5;
    settle();
    n_chk++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h3000) $display("[TB] FAIL promo_load got=%0d/%h exp=1/00003000", proc2mem_command, proc2mem_addr); else n_pass++;
    tick();
    mem2proc_transaction_tag = 4'd0; demand_valid = 1'b1; demand_addr = 32'h3000;
    settle();
    n_chk++; if (demand_ready !== 1'b1 || proc2mem_command !== 2'd0) $display("[TB] FAIL promo_merge got=%b/%0d exp=1/0", demand_ready, proc2mem_command); else n_pass++;
    tick();
    demand_valid = 1'b0; mem2proc_data_tag = 4'd5; mem2proc_data = 64'h3333;
    tick();
    set_idle();
    n_chk++; if (fill_valid !== 1'b1 || fill_is_prefetch !== 1'b0 || fill_addr !== 32'h3000) $display("[TB] FAIL promo_fill got=%b/%b/%h exp=1/0/00003000", fill_valid, fill_is_prefetch, fill_addr); else n_pass++;
    // promotion in the same cycle as the data return
    pref_valid = 1'b1; pref_addr = 32'h3100;
    tick();
    pref_valid = 1'b0; mem2proc_transaction_tag = 4'd6;
    tick();
    mem2proc_transaction_tag = 4'd0; demand_valid = 1'b1; demand_addr = 32'h3104;
    mem2proc_data_tag = 4'd6; mem2proc_data = 64'h3131;
    tick();
    set_idle();
    n_chk++; if (fill_valid !== 1'b1 || fill_is_prefetch !== 1'b0 || fill_addr !== 32'h3100) $display("[TB] FAIL promo_same_cycle got=%b/%b/%h exp=1/0/00003100", fill_valid, fill_is_prefetch, fill_addr); else n_pass++;
    // pure prefetch return stays marked as prefetch
    pref_valid = 1'b1; pref_addr = 32'h3200;
    tick();
    pref_valid = 1'b0; mem2proc_transaction_tag = 4'd4;
    tick();
    mem2proc_transaction_tag = 4'd0; mem2proc_data_tag = 4'd4; mem2proc_data = 64'h3232;
    tick();
    set_idle();
    n_chk++; if (fill_valid !== 1'b1 || fill_is_prefetch !== 1'b1 || fill_addr !== 32'h3200) $display("[TB] FAIL pf_fill got=%b/%b/%h exp=1/1/00003200", fill_valid, fill_is_prefetch, fill_addr); else n_pass++;
  endtask

  task automatic test_reject_retry();
    do_reset();
    demand_valid = 1'b1; demand_addr = 32'h4000;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_chk++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h4000 || demand_ready !== 1'b0) $display("[TB] FAIL retry_%0d got=%0d/%h/%b exp=1/00004000/0", i, proc2mem_command, proc2mem_addr, demand_ready); else n_pass++;
      tick();
    end
    mem2proc_transaction_tag = 4'd7;
    settle();
    n_chk++; if (demand_ready !== 1'b1) $display("[TB] FAIL retry_accept got=%b exp=1", demand_ready); else n_pass++;
    tick();
    set_idle();
    n_chk++; if (outstanding_cnt !== 4'd1 || tag_err !== 1'b0) $display("[TB] FAIL retry_status got=%0d/%b exp=1/0", outstanding_cnt, tag_err); else n_pass++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    dmem_claim = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pref_valid = 1'b1; pref_addr = 32'h5000 + 32'(8 * i);
      settle();
      n_chk++; if (pref_ready !== (i < 4)) $display("[TB] FAIL pref_ready_%0d got=%b exp=%b", i, pref_ready, (i < 4)); else n_pass++;
      tick();
    end
    pref_valid = 1'b0; dmem_claim = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem2proc_transaction_tag = 4'(i + 1);
      settle();
      n_chk++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h5000 + 32'(8 * i)) $display("[TB] FAIL drain_%0d got=%0d/%h exp=1/%h", i, proc2mem_command, proc2mem_addr, 32'h5000 + 32'(8 * i)); else n_pass++;
      tick();
    end
    mem2proc_transaction_tag = 4'd0;
    settle();
    n_chk++; if (proc2mem_command !== 2'd0 || pref_ready !== 1'b1 || outstanding_cnt !== 4'd4) $display("[TB] FAIL drain_end got=%0d/%b/%0d exp=0/1/4", proc2mem_command, pref_ready, outstanding_cnt); else n_pass++;
  endtask

  task automatic test_tag_err_and_reset();
    do_reset();
    mem2proc_data_tag = 4'd9; mem2proc_data = 64'h9999;
    tick();
    set_idle();
    n_chk++; if (fill_valid !== 1'b0 || tag_err !== 1'b1) $display("[TB] FAIL bad_tag got=%b/%b exp=0/1", fill_valid, tag_err); else n_pass++;
    tick();
    n_chk++; if (tag_err !== 1'b1) $display("[TB] FAIL err_sticky got=%b exp=1", tag_err); else n_pass++;
    demand_valid = 1'b1; demand_addr = 32'h6000; mem2proc_transaction_tag = 4'd2;
    tick();
    demand_addr = 32'h6040; pref_valid = 1'b1; pref_addr = 32'h6008; mem2proc_transaction_tag = 4'd3;
    reset = 1'b1;
    #1;
    n_chk++; if ({proc2mem_command, proc2mem_addr, demand_ready, pref_ready} !== 36'b01) $display("[TB] FAIL midreset_comb got=%0d/%h/%b/%b exp=0/0/0/1", proc2mem_command, proc2mem_addr, demand_ready, pref_ready); else n_pass++;
    n_chk++; if ({fill_valid, outstanding_cnt, tag_err} !== 6'd0) $display("[TB] FAIL midreset_regs got=%b/%0d/%b exp=0/0/0", fill_valid, outstanding_cnt, tag_err); else n_pass++;
    tick();
    set_idle();
    reset = 1'b0;
    mem2proc_data_tag = 4'd2; mem2proc_data = 64'h6666;
    tick();
    set_idle();
    n_chk++; if (fill_valid !== 1'b0 || tag_err !== 1'b1) $display("[TB] FAIL stale_return got=%b/%b exp=0/1", fill_valid, tag_err); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0]  e_cmd;
    logic [31:0] e_addr, dl, hd;
    logic        e_dr, e_pr, do_pop, promote, alloc_pf;
    int          r, sz;
    do_reset();
    for (int t = 0; t < 16; t++) begin m_valid[t] = 0; m_addr[t] = '0; m_pf[t] = 0; end
    m_fifo.delete();
    m_fv = 0; m_fp = 0; m_err = 0; m_fa = '0; m_fd = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      dmem_claim   = ($urandom_range(0, 4) == 0);
      demand_valid = ($urandom_range(0, 2) == 0);
      demand_addr  = 32'h8000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
      pref_valid   = ($urandom_range(0, 1) == 1);
      pref_addr    = 32'h8000 + 32'($urandom_range(0, 9) * 8) + 32'($urandom_range(0, 7));
      r = $urandom_range(0, 99);
      mem2proc_transaction_tag = (r < 3) ? 4'($urandom_range(1, 15)) : (r < 60) ? pick_tag(1'b0) : 4'd0;
      r = $urandom_range(0, 99);
      mem2proc_data_tag = (r < 3) ? 4'($urandom_range(1, 15)) : (r < 45) ? pick_tag(1'b1) : 4'd0;
      mem2proc_data = {$urandom, $urandom};
      dl = line_of(demand_addr);
      sz = m_fifo.size();
      hd = (sz > 0) ? m_fifo[0] : 32'd0;
      e_cmd = 2'd0; e_addr = '0; e_dr = 0; do_pop = 0; promote = 0; alloc_pf = 0;
      if (!dmem_claim) begin
        if (demand_valid) begin
          if (in_flight(dl)) begin e_dr = 1; promote = 1; end
          else begin e_cmd = 2'd1; e_addr = dl; e_dr = (mem2proc_transaction_tag != 0); end
        end else if (sz > 0) begin
          if (in_flight(hd)) do_pop = 1;
          else begin e_cmd = 2'd1; e_addr = hd; alloc_pf = 1; do_pop = (mem2proc_transaction_tag != 0); end
        end
      end
      e_pr = (sz < 4);
      settle();
      n_chk++; if ({proc2mem_command, proc2mem_addr, demand_ready, pref_ready} !== {e_cmd, e_addr, e_dr, e_pr}) $display("[TB] FAIL rnd_issue cyc=%0d got=%0d/%h/%b/%b exp=%0d/%h/%b/%b", cyc, proc2mem_command, proc2mem_addr, demand_ready, pref_ready, e_cmd, e_addr, e_dr, e_pr); else n_pass++;
      n_chk++; if ({fill_valid, fill_addr, fill_data, fill_is_prefetch} !== {m_fv, m_fa, m_fd, m_fp}) $display("[TB] FAIL rnd_fill cyc=%0d got=%b/%h/%h/%b exp=%b/%h/%h/%b", cyc, fill_valid, fill_addr, fill_data, fill_is_prefetch, m_fv, m_fa, m_fd, m_fp); else n_pass++;
      n_chk++; if ({outstanding_cnt, tag_err} !== {4'(model_count()), m_err}) $display("[TB] FAIL rnd_status cyc=%0d got=%0d/%b exp=%0d/%b", cyc, outstanding_cnt, tag_err, model_count(), m_err); else n_pass++;
      // advance the model by one clock edge
      if (promote) for (int t = 1; t < 16; t++) if (m_valid[t] && m_addr[t] == dl) m_pf[t] = 0;
      m_fv = 0;
      if (mem2proc_data_tag != 0) begin
        if (m_valid[mem2proc_data_tag]) begin
          m_fv = 1; m_fa = m_addr[mem2proc_data_tag]; m_fd = mem2proc_data;
          m_fp = m_pf[mem2proc_data_tag]; m_valid[mem2proc_data_tag] = 0;
        end else m_err = 1;
      end
      if (e_cmd == 2'd1 && mem2proc_transaction_tag != 0) begin
        if (m_valid[mem2proc_transaction_tag]) m_err = 1;
        m_valid[mem2proc_transaction_tag] = 1;
        m_addr[mem2proc_transaction_tag]  = e_addr;
        m_pf[mem2proc_transaction_tag]    = alloc_pf;
      end
      if (do_pop) void'(m_fifo.pop_front());
      if (pref_valid && (sz < 4 || do_pop)) m_fifo.push_back(line_of(pref_addr));
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_demand_fill();
    test_claim_prefetch();
    test_promotion();
    test_reject_retry();
    test_fifo_full();
    test_tag_err_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
